// File: rtl/step_ctl_if.sv
// Command channel into the step controller.
// Handshake: a command transfers at a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_op/cmd_count must be stable while cmd_valid
// is high; cmd_ready may depend combinationally on cmd_op.
interface step_ctl_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/step_ctl.sv
// Step controller: produces a registered clock-gate enable for a CPU core,
// supporting free-run, single-step and N-step bursts, with breakpoint and
// halt stopping, plus a wrapping count of gated edges.
module step_ctl #(
  parameter int CNT_W  = 8,
  parameter int EDGE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  step_ctl_if.slave         cmd,
  input  logic              brk,
  output logic              gate_en,
  output logic              running,
  output logic [CNT_W-1:0]  steps_left,
  output logic              done,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_BURST  = 2'd2
  } state_t;

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_BURST = 2'b11;

  state_t           state;
  logic             accept;
  logic             halt_cmd;
  logic             last_step;
  logic [CNT_W-1:0] steps_dec;

  // Ready is open for anything while halted; while active only HALT gets in.
  always_comb begin
    cmd.cmd_ready = (state == S_HALTED) || (cmd.cmd_op == OP_HALT);
  end

  // Decode helpers for the sequential block.
  always_comb begin
    accept    = cmd.cmd_valid && cmd.cmd_ready;
    halt_cmd  = accept && (cmd.cmd_op == OP_HALT);
    steps_dec = steps_left - CNT_W'(1);
    // gate_en is always high in BURST, so this edge consumes the final step.
    last_step = (state == S_BURST) && gate_en && (steps_left == CNT_W'(1));
  end

  assign state_dbg = state;

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HALTED;
      gate_en    <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
      edge_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (gate_en) begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end
      case (state)
        S_HALTED: begin
          // brk is ignored here; only commands matter.
          if (accept) begin
            case (cmd.cmd_op)
              OP_RUN: begin
                state   <= S_RUN;
                gate_en <= 1'b1;
                running <= 1'b1;
              end
              OP_STEP: begin
                state      <= S_BURST;
                steps_left <= CNT_W'(1);
                gate_en    <= 1'b1;
                running    <= 1'b1;
              end
              OP_BURST: begin
                if (cmd.cmd_count == '0) begin
                  // Empty burst completes immediately without gating an edge.
                  steps_left <= '0;
                  done       <= 1'b1;
                end else begin
                  state      <= S_BURST;
                  steps_left <= cmd.cmd_count;
                  gate_en    <= 1'b1;
                  running    <= 1'b1;
                end
              end
              default: ;  // HALT while halted does nothing
            endcase
          end
        end
        default: begin
          // Active (RUN or BURST): the current edge is gated.
          if (state == S_BURST && gate_en) begin
            steps_left <= steps_dec;
          end
          if (brk || last_step) begin
            // brk keeps the (normally decremented) step count; a brk on the
            // final step is just the ordinary completion.
            state   <= S_HALTED;
            gate_en <= 1'b0;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (halt_cmd) begin
            state      <= S_HALTED;
            gate_en    <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b1;
            steps_left <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_ctl.sv
// Bench for step_ctl: directed scenarios followed by random commands,
// breakpoints and resets, checked cycle by cycle against a reference model.
module tb_step_ctl;
  localparam int CNT_W  = 8;
  localparam int EDGE_W = 4;
  localparam int REC_W  = 3 + CNT_W + EDGE_W + 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  logic brk;
  always #5 clk = ~clk;

  step_ctl_if #(.CNT_W(CNT_W)) cmd_if ();

  logic              gate_en;
  logic              running;
  logic [CNT_W-1:0]  steps_left;
  logic              done;
  logic [EDGE_W-1:0] edge_cnt;
  logic [1:0]        state_dbg;

  step_ctl #(.CNT_W(CNT_W), .EDGE_W(EDGE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if.slave),
    .brk        (brk),
    .gate_en    (gate_en),
    .running    (running),
    .steps_left (steps_left),
    .done       (done),
    .edge_cnt   (edge_cnt),
    .state_dbg  (state_dbg)
  );

  // Reference model: activity mode, remaining steps, edges seen, last-cycle done.
  localparam int M_IDLE  = 0;
  localparam int M_FREE  = 1;
  localparam int M_STEPS = 2;
  int m_mode, m_rem, m_edges;
  bit m_done;

  logic [REC_W-1:0] exp_q[$];
  int vectors    = 0;
  int miscompare = 0;

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_rem   = 0;
    m_edges = 0;
    m_done  = 1'b0;
  endfunction

  // Advance the model by one clock edge given the inputs present at it.
  function automatic void model_step(input bit v, input bit [1:0] op, input int cnt,
                                     input bit b, input bit r, input bit rdy);
    bit active;
    if (r) begin
      model_reset();
      return;
    end
    active = (m_mode != M_IDLE);
    m_done = 1'b0;
    if (active) m_edges = (m_edges + 1) % (1 << EDGE_W);
    if (!active) begin
      if (v && rdy) begin
        if (op == 2'd1) m_mode = M_FREE;
        else if (op == 2'd2) begin m_mode = M_STEPS; m_rem = 1; end
        else if (op == 2'd3) begin
          if (cnt == 0) begin m_rem = 0; m_done = 1'b1; end
          else begin m_mode = M_STEPS; m_rem = cnt; end
        end
      end
    end else begin
      if (m_mode == M_STEPS) m_rem = m_rem - 1;
      if (b || (m_mode == M_STEPS && m_rem == 0)) begin
        m_mode = M_IDLE;
        m_done = 1'b1;
      end else if (v && op == 2'd0) begin
        m_mode = M_IDLE;
        m_rem  = 0;
        m_done = 1'b1;
      end
    end
  endfunction

  // Driver: present one cycle of inputs, record what the DUT must show
  // during this cycle, then advance the model across the coming edge.
  task automatic drive(input bit v, input bit [1:0] op, input int cnt,
                       input bit b, input bit r);
    bit exp_ready;
    bit act;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_count = CNT_W'(cnt);
    brk = b;
    rst = r;
    act = (m_mode != M_IDLE);
    exp_ready = !act || (op == 2'd0);
    exp_q.push_back({act, act, m_done, CNT_W'(m_rem), EDGE_W'(m_edges), exp_ready});
    model_step(v, op, cnt, b, r, exp_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd1, 0, 1'b0, 1'b0);
  endtask

  // Monitor / scoreboard: compare every presented cycle against the queue.
  always @(negedge clk) begin
    logic [REC_W-1:0] exp_v;
    logic [REC_W-1:0] got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {gate_en, running, done, steps_left, edge_cnt, cmd_if.cmd_ready};
      vectors++;
      if (got_v !== exp_v) begin
        miscompare++;
        $display("FAIL outputs @%0t: got gate=%b run=%b done=%b steps=%0d edges=%0d rdy=%b, want gate=%b run=%b done=%b steps=%0d edges=%0d rdy=%b",
                 $time, got_v[REC_W-1], got_v[REC_W-2], got_v[REC_W-3],
                 got_v[EDGE_W+CNT_W:EDGE_W+1], got_v[EDGE_W:1], got_v[0],
                 exp_v[REC_W-1], exp_v[REC_W-2], exp_v[REC_W-3],
                 exp_v[EDGE_W+CNT_W:EDGE_W+1], exp_v[EDGE_W:1], exp_v[0]);
      end
    end
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_count = '0;
    brk = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Single step after reset.
    drive(1'b1, 2'd2, 0, 1'b0, 1'b0);
    idle(3);
    // Burst of 5 with a refused RUN and a visible-but-unsent HALT mid-burst.
    drive(1'b1, 2'd3, 5, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 2'd1, 0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 0, 1'b0, 1'b0);
    idle(4);
    // Burst aborted by HALT.
    drive(1'b1, 2'd3, 5, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 2'd0, 0, 1'b0, 1'b0);
    idle(2);
    // Halt while halted is a no-op.
    drive(1'b1, 2'd0, 0, 1'b0, 1'b0);
    idle(1);
    // RUN then breakpoint, then breakpoints while halted.
    drive(1'b1, 2'd1, 0, 1'b0, 1'b0);
    idle(10);
    drive(1'b0, 2'd1, 0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 2'd1, 0, 1'b1, 1'b0);
    drive(1'b0, 2'd1, 0, 1'b1, 1'b0);
    idle(1);
    // Burst of 8 broken after the third gated edge; then empty burst.
    drive(1'b1, 2'd3, 8, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 2'd1, 0, 1'b1, 1'b0);
    idle(2);
    drive(1'b1, 2'd3, 0, 1'b0, 1'b0);
    idle(2);
    // brk together with HALT, and brk on the final burst step.
    drive(1'b1, 2'd3, 4, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 0, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 2'd3, 2, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 2'd1, 0, 1'b1, 1'b0);
    idle(2);
    // Long RUN wraps the edge counter, then reset mid-run.
    drive(1'b1, 2'd1, 0, 1'b0, 1'b0);
    idle(17);
    drive(1'b0, 2'd1, 0, 1'b0, 1'b1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 9)), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 199) == 0));
    end
    idle(2);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompare++;
      $display("FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
    $finish;
  end
endmodule

// File: doc/step_ctl.md
STEP_CTL -- requirements
Module: step_ctl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of burst count and remaining-step count.
REQ-002 The block SHALL have parameter EDGE_W, default 16, giving the width of the gated-edge counter.
REQ-003 The block SHALL have port clk  input  1  free-running system clock, the same clock fed to the downstream edge gate.
REQ-004 The block SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 The block SHALL have port cmd_valid  input  1  command request.
REQ-006 The block SHALL have port cmd_ready  output  1  command accept.
REQ-007 The block SHALL have port cmd_op  input  2  operation: 00 HALT, 01 RUN, 10 STEP, 11 BURST.
REQ-008 The block SHALL have port cmd_count  input  CNT_W  burst length, used only by BURST.
REQ-009 The block SHALL have port brk  input  1  breakpoint request from the CPU datapath, synchronous to clk.
REQ-010 The block SHALL have port gate_en  output  1  registered enable to the edge gate; high at a clk rising edge means that edge passes.
REQ-011 The block SHALL have port running  output  1  high when state is not HALTED.
REQ-012 The block SHALL have port steps_left  output  CNT_W  remaining burst steps.
REQ-013 The block SHALL have port done  output  1  single-cycle completion/stop pulse.
REQ-014 The block SHALL have port edge_cnt  output  EDGE_W  count of rising edges with gate_en high.

Function
REQ-015 The block SHALL implement states HALTED, RUN and BURST; STEP SHALL be handled as BURST with count 1.
REQ-016 A command SHALL be accepted at a rising edge where cmd_valid and cmd_ready are both high.
REQ-017 cmd_ready SHALL be combinational: high in HALTED for any op; in RUN or BURST, high only when cmd_op is HALT.
REQ-018 In HALTED, accepted RUN SHALL enter RUN, with gate_en high from the next cycle until a stop.
REQ-019 In HALTED, accepted BURST with count N>0 (or STEP, N=1) SHALL enter BURST, load steps_left=N, and hold gate_en high for exactly N consecutive cycles starting the cycle after acceptance.
REQ-020 steps_left SHALL decrement by 1 at every rising edge in BURST where gate_en is high.
REQ-021 After the Nth gated edge, the block SHALL enter HALTED: gate_en low, steps_left 0, done high for exactly that one cycle.
REQ-022 In HALTED, accepted BURST with count 0 SHALL leave state HALTED, keep gate_en low, and pulse done the next cycle.
REQ-023 In HALTED, accepted HALT SHALL be a no-op with no done pulse.
REQ-024 In RUN or BURST, accepted HALT SHALL enter HALTED the next cycle: gate_en low, steps_left cleared to 0, done pulsed.
REQ-025 In RUN or BURST, brk high at a rising edge SHALL enter HALTED the next cycle with gate_en low, done pulsed and steps_left held (not decremented for the stopping cycle if gate_en was low, otherwise decremented normally).
REQ-026 brk and an accepted HALT in the same cycle SHALL behave as brk (steps_left preserved).
REQ-027 brk coinciding with the final burst step SHALL produce one completion only: steps_left 0 and a single done pulse.
REQ-028 brk in HALTED SHALL be ignored.
REQ-029 edge_cnt SHALL increment by 1 at every rising edge where gate_en is high and SHALL wrap modulo 2^EDGE_W.
REQ-030 gate_en, running, done, steps_left and edge_cnt SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-031 rst high at a rising edge SHALL force HALTED, gate_en 0, running 0, done 0, steps_left 0 and edge_cnt 0, overriding any command or brk.
REQ-032 rst asserted mid-RUN or mid-BURST SHALL abort with no done pulse, and gate_en SHALL be low in the cycle after the reset edge.

Verification
REQ-033 Reset, then STEP -> gate_en high exactly 1 cycle, done pulse in the following cycle, edge_cnt=1.
REQ-034 BURST count=5 -> gate_en high 5 cycles, steps_left 5,4,3,2,1,0, single done, edge_cnt=5; HALT/RUN issued mid-burst sees cmd_ready=0 for RUN and 1 for HALT.
REQ-035 RUN, brk pulsed 10 cycles later -> gate_en low the next cycle, done pulse, running 0; brk repeated while HALTED -> no effect.
REQ-036 BURST count=8, brk after 3 gated edges -> steps_left=5 held; BURST count=0 -> done pulse, no gated edge.
REQ-037 EDGE_W=4, RUN for 17 cycles -> edge_cnt wraps to 1; rst mid-run -> all outputs 0, no done.
